// File: rtl/deserializer_fifo.sv
// Serial-to-parallel deserializer (MSB first) feeding a small output FIFO.
// Reports truncated frames on err_o and words dropped on a full FIFO on ovf_o.
module deserializer_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_data_i,
    input  logic             ser_val_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_val_o,
    input  logic             data_rdy_i,
    output logic             err_o,
    output logic             ovf_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   occ_r;
    logic [WIDTH-1:0] data_r;
    logic             val_r;
    logic             err_r;
    logic             ovf_r;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] word_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W:0]   occ_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    // Frame assembly, FIFO push/pop decisions and next-head computation
    always_comb begin
        push_s       = ser_val_i && (cnt_r == CNT_LAST);
        word_s       = {sr_r[WIDTH-2:0], ser_data_i};
        pop_s        = val_r && data_rdy_i;
        full_s       = (occ_r == OCC_FULL);
        wr_en_s      = push_s && (!full_s || pop_s);
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        case ({wr_en_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + (PTR_W + 1)'(1);
            2'b01:   occ_nxt_s = occ_r - (PTR_W + 1)'(1);
            default: occ_nxt_s = occ_r;
        endcase
        // A word written this edge becomes the head only if it lands on the next read slot
        if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = word_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Bit counter, shift register and truncation pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= '0;
            sr_r  <= '0;
            err_r <= 1'b0;
        end else begin
            err_r <= !ser_val_i && (cnt_r != '0);
            if (ser_val_i) begin
                sr_r <= word_s;
                if (cnt_r == CNT_LAST) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            occ_r    <= occ_nxt_s;
        end
    end

    // Registered output stage mirrors the head entry the FIFO will hold after this edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_r <= '0;
            val_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            data_r <= head_nxt_s;
            val_r  <= (occ_nxt_s != '0);
            ovf_r  <= push_s && full_s && !pop_s;
        end
    end

    assign data_o     = data_r;
    assign data_val_o = val_r;
    assign err_o      = err_r;
    assign ovf_o      = ovf_r;

endmodule

// File: tb/tb_deserializer_fifo.sv
// Directed self-checking bench for deserializer_fifo (WIDTH=6, DEPTH=4).
module tb_deserializer_fifo;

    logic       clk_i;
    logic       rst_i;
    logic       ser_data_i;
    logic       ser_val_i;
    logic [5:0] data_o;
    logic       data_val_o;
    logic       data_rdy_i;
    logic       err_o;
    logic       ovf_o;

    int checks = 0;
    int errors = 0;

    deserializer_fifo #(.WIDTH(6), .DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ser_data_i (ser_data_i),
        .ser_val_i  (ser_val_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .data_rdy_i (data_rdy_i),
        .err_o      (err_o),
        .ovf_o      (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Shift out the top nbits of w, MSB first; ser_val_i is left high.
    task automatic send_bits(input logic [5:0] w, input int nbits);
        for (int i = 5; i > 5 - nbits; i--) begin
            ser_val_i  = 1'b1;
            ser_data_i = w[i];
            step();
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        step();
        step();
        checks++; if (data_o !== 6'h00) begin errors++; $display("FAIL reset_data got %h exp %h", data_o, 6'h00); end
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL reset_val got %b exp %b", data_val_o, 1'b0); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp %b", err_o, 1'b0); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp %b", ovf_o, 1'b0); end
        rst_i = 1'b1;
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL idle_val got %b exp %b", data_val_o, 1'b0); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL idle_err got %b exp %b", err_o, 1'b0); end
    endtask

    task automatic test_single;
        data_rdy_i = 1'b1;
        send_bits(6'b101101, 5);
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL single_early_val got %b exp %b", data_val_o, 1'b0); end
        ser_data_i = 1'b1;
        step();
        checks++; if (data_val_o !== 1'b1) begin errors++; $display("FAIL single_val got %b exp %b", data_val_o, 1'b1); end
        checks++; if (data_o !== 6'b101101) begin errors++; $display("FAIL single_data got %h exp %h", data_o, 6'b101101); end
        ser_val_i = 1'b0;
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp %b", data_val_o, 1'b0); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err got %b exp %b", err_o, 1'b0); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] v;
        v = 12'hFC0;
        data_rdy_i = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            ser_val_i  = 1'b1;
            ser_data_i = v[i];
            step();
            checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err bit %0d got %b exp %b", i, err_o, 1'b0); end
            if (i == 6) begin
                checks++; if (data_o !== 6'h3F || data_val_o !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp %h/%b", data_o, data_val_o, 6'h3F, 1'b1); end
            end
        end
        checks++; if (data_o !== 6'h3F) begin errors++; $display("FAIL b2b_hold got %h exp %h", data_o, 6'h3F); end
        ser_val_i  = 1'b0;
        data_rdy_i = 1'b1;
        step();
        checks++; if (data_o !== 6'h00 || data_val_o !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp %h/%b", data_o, data_val_o, 6'h00, 1'b1); end
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp %b", data_val_o, 1'b0); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_gap_err got %b exp %b", err_o, 1'b0); end
        data_rdy_i = 1'b0;
    endtask

    task automatic test_truncation;
        data_rdy_i = 1'b1;
        send_bits(6'b111000, 3);
        ser_val_i = 1'b0;
        step();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL trunc_err got %b exp %b", err_o, 1'b1); end
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL trunc_nopush got %b exp %b", data_val_o, 1'b0); end
        step();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL trunc_err_end got %b exp %b", err_o, 1'b0); end
        send_bits(6'h15, 6);
        checks++; if (data_o !== 6'h15 || data_val_o !== 1'b1) begin errors++; $display("FAIL trunc_next got %h/%b exp %h/%b", data_o, data_val_o, 6'h15, 1'b1); end
        ser_val_i = 1'b0;
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL trunc_drain got %b exp %b", data_val_o, 1'b0); end
    endtask

    task automatic test_overflow;
        logic [5:0] w [5];
        w[0] = 6'h01; w[1] = 6'h12; w[2] = 6'h23; w[3] = 6'h34; w[4] = 6'h2A;
        data_rdy_i = 1'b0;
        for (int f = 0; f < 5; f++) begin
            send_bits(w[f], 6);
            checks++; if (ovf_o !== (f == 4)) begin errors++; $display("FAIL ovf_frame%0d got %b exp %b", f, ovf_o, (f == 4)); end
        end
        ser_val_i = 1'b0;
        step();
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got %b exp %b", ovf_o, 1'b0); end
        checks++; if (data_o !== 6'h01 || data_val_o !== 1'b1) begin errors++; $display("FAIL ovf_head got %h/%b exp %h/%b", data_o, data_val_o, 6'h01, 1'b1); end
        data_rdy_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            checks++; if (data_o !== w[k] || data_val_o !== 1'b1) begin errors++; $display("FAIL ovf_drain%0d got %h/%b exp %h/%b", k, data_o, data_val_o, w[k], 1'b1); end
        end
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp %b", data_val_o, 1'b0); end
        data_rdy_i = 1'b0;
    endtask

    task automatic test_full_pop;
        logic [5:0] w [5];
        w[0] = 6'h05; w[1] = 6'h16; w[2] = 6'h27; w[3] = 6'h38; w[4] = 6'h3C;
        data_rdy_i = 1'b0;
        for (int f = 0; f < 4; f++) begin
            send_bits(w[f], 6);
        end
        send_bits(w[4], 5);
        data_rdy_i = 1'b1;
        ser_data_i = w[4][0];
        step();
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp %b", ovf_o, 1'b0); end
        checks++; if (data_o !== w[1] || data_val_o !== 1'b1) begin errors++; $display("FAIL fullpop_head got %h/%b exp %h/%b", data_o, data_val_o, w[1], 1'b1); end
        ser_val_i = 1'b0;
        for (int k = 2; k < 5; k++) begin
            step();
            checks++; if (data_o !== w[k] || data_val_o !== 1'b1) begin errors++; $display("FAIL fullpop_drain%0d got %h/%b exp %h/%b", k, data_o, data_val_o, w[k], 1'b1); end
        end
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp %b", data_val_o, 1'b0); end
        data_rdy_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        data_rdy_i = 1'b0;
        send_bits(6'h2D, 6);
        send_bits(6'b101100, 4);
        rst_i = 1'b0;
        #1;
        checks++; if (data_o !== 6'h00) begin errors++; $display("FAIL rstmid_data got %h exp %h", data_o, 6'h00); end
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL rstmid_val got %b exp %b", data_val_o, 1'b0); end
        checks++; if (err_o !== 1'b0 || ovf_o !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b exp %b%b", err_o, ovf_o, 1'b0, 1'b0); end
        ser_val_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstmid_noerr got %b exp %b", err_o, 1'b0); end
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL rstmid_empty got %b exp %b", data_val_o, 1'b0); end
        send_bits(6'h33, 6);
        checks++; if (data_o !== 6'h33 || data_val_o !== 1'b1) begin errors++; $display("FAIL rstmid_fresh got %h/%b exp %h/%b", data_o, data_val_o, 6'h33, 1'b1); end
        ser_val_i  = 1'b0;
        data_rdy_i = 1'b1;
        step();
        checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL rstmid_drain got %b exp %b", data_val_o, 1'b0); end
    endtask

    initial begin
        rst_i      = 1'b0;
        ser_data_i = 1'b0;
        ser_val_i  = 1'b0;
        data_rdy_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_truncation();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserializer_fifo.md
DESERIALIZER_FIFO -- requirements
Module: deserializer_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 6, giving the number of bits per serial word.
REQ-002 SHALL have parameter DEPTH, default 4 (power of 2, >=2), giving the number of output FIFO entries.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port ser_data_i, input, 1, the serial data bit, MSB first.
REQ-006 SHALL have port ser_val_i, input, 1, high for every cycle that ser_data_i carries a valid bit of a frame.
REQ-007 SHALL have port data_o, output, WIDTH, the parallel word at the FIFO head.
REQ-008 SHALL have port data_val_o, output, 1, high when data_o holds a valid word (FIFO not empty).
REQ-009 SHALL have port data_rdy_i, input, 1, the downstream ready signal.
REQ-010 SHALL have port err_o, output, 1, a one-cycle pulse on a truncated frame.
REQ-011 SHALL have port ovf_o, output, 1, a one-cycle pulse when a completed word is dropped because the FIFO is full.

Function
REQ-012 SHALL keep a bit counter cnt (0..WIDTH-1) and a WIDTH-bit shift register sr.
REQ-013 SHALL, on each edge with ser_val_i=1 and cnt<WIDTH-1, set sr <= {sr[WIDTH-2:0], ser_data_i} and cnt <= cnt+1.
REQ-014 SHALL, on an edge with ser_val_i=1 and cnt==WIDTH-1, form word {sr[WIDTH-2:0], ser_data_i}, push it to the FIFO, and set cnt <= 0.
REQ-015 SHALL treat ser_val_i held high across more than WIDTH cycles as back-to-back frames with no gap, so 2*WIDTH valid cycles yield two words.
REQ-016 SHALL, on an edge with ser_val_i=0 and cnt!=0, discard the partial word, set cnt <= 0, and pulse err_o high for exactly the following cycle.
REQ-017 SHALL leave cnt, sr and err_o unchanged/low while ser_val_i=0 and cnt==0 (idle gap, no error).
REQ-018 SHALL implement the FIFO as DEPTH entries with rd/wr pointers that wrap modulo DEPTH and an occupancy count 0..DEPTH.
REQ-019 SHALL drive data_val_o = (occupancy != 0) and data_o = entry at rd pointer, both registered state, with no combinational path from ser_* inputs.
REQ-020 SHALL pop (advance rd pointer) on an edge where data_val_o=1 and data_rdy_i=1; data_rdy_i is ignored while data_val_o=0.
REQ-021 SHALL give latency of one cycle: a word whose last bit is sampled at edge N appears with data_val_o=1 after edge N when the FIFO was empty.
REQ-022 SHALL, on push with occupancy==DEPTH and no pop on the same edge, drop the word, leave FIFO unchanged, and pulse ovf_o for one cycle.
REQ-023 SHALL, on push and pop on the same edge with FIFO full, accept both with occupancy staying DEPTH and no ovf_o.
REQ-024 SHALL, on push and pop on the same edge with FIFO non-empty and not full, keep occupancy unchanged.
REQ-025 SHALL keep data_o and data_val_o stable while data_val_o=1 and data_rdy_i=0.

Reset
REQ-026 SHALL, on rst_i=0, asynchronously clear cnt, sr, FIFO pointers, occupancy and all storage entries to 0.
REQ-027 SHALL hold data_o=0, data_val_o=0, err_o=0 and ovf_o=0 while in reset.
REQ-028 SHALL discard any partial frame on reset mid-frame without asserting err_o; the first frame after reset release starts at cnt=0.

Verification
REQ-029 SHALL cover a single frame: ser_val_i high 6 cycles with bits 1,0,1,1,0,1 and data_rdy_i=1 -> data_o=6'b101101 and data_val_o=1 for one cycle, one cycle after the last bit.
REQ-030 SHALL cover back-to-back frames: ser_val_i high 12 cycles carrying 6'h3F then 6'h00 -> two words in order, 3F then 00, and err_o stays 0.
REQ-031 SHALL cover truncation: ser_val_i high 3 cycles then low -> err_o=1 for exactly one cycle, no word pushed, and the next full frame decodes correctly.
REQ-032 SHALL cover overflow: data_rdy_i=0 with 5 frames A..E -> 4 words held, ovf_o pulses once on frame E, and draining yields A,B,C,D.
REQ-033 SHALL cover full with simultaneous pop: FIFO full with data_rdy_i=1 on the edge a 5th word completes -> no ovf_o, occupancy stays 4, and E is the last word out.
REQ-034 SHALL cover reset mid-frame: rst_i low after 4 bits -> all outputs 0 and no err_o; a fresh 6-bit frame after release decodes correctly.
